// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO slave: bus polarities, register map and edge encoding.
package gpio_ctrl_pkg;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // Register select field inside the word address
    localparam int GPIO_ADDR_MSB = 3;
    localparam int GPIO_ADDR_LSB = 0;
    typedef logic [GPIO_ADDR_MSB:GPIO_ADDR_LSB] gpio_addr_t;

    localparam gpio_addr_t GPIO_ADDR_IN_DATA    = 4'd0;
    localparam gpio_addr_t GPIO_ADDR_OUT_DATA   = 4'd1;
    localparam gpio_addr_t GPIO_ADDR_OUT_SET    = 4'd2;
    localparam gpio_addr_t GPIO_ADDR_OUT_CLR    = 4'd3;
    localparam gpio_addr_t GPIO_ADDR_IO_DATA    = 4'd4;
    localparam gpio_addr_t GPIO_ADDR_IO_DIR     = 4'd5;
    localparam gpio_addr_t GPIO_ADDR_IRQ_MASK   = 4'd6;
    localparam gpio_addr_t GPIO_ADDR_IRQ_EDGE   = 4'd7;
    localparam gpio_addr_t GPIO_ADDR_IRQ_STATUS = 4'd8;

    localparam logic GPIO_EDGE_RISE = 1'b0;
    localparam logic GPIO_EDGE_FALL = 1'b1;

    localparam int GPIO_IN_CH_DEF  = 8;
    localparam int GPIO_OUT_CH_DEF = 8;
    localparam int GPIO_IO_CH_DEF  = 8;
endpackage

// File: rtl/gpio_ctrl_if.sv
// Peripheral bus connection between a bus master and the GPIO slave.
interface gpio_ctrl_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              CS_;
    logic              As_;
    logic              RW;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              Rdy_;

    modport master (output CS_, As_, RW, Addr, WrData, input RdData, Rdy_);
    modport slave  (input CS_, As_, RW, Addr, WrData, output RdData, Rdy_);
endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser plus a delayed copy for rise/fall pulse generation.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    logic [WIDTH-1:0] sync_p0, sync_p1, dly_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            dly_p2  <= '0;
        end else begin
            // p0/p1: metastability filter; p2: previous synchronised value
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign sync = sync_p1;
    assign rise = sync_p1 & ~dly_p2;
    assign fall = ~sync_p1 & dly_p2;
endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO bus slave. Edge interrupts exist only when GPIO_IRQ_EN is defined.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int IN_CH  = GPIO_IN_CH_DEF,
    parameter int OUT_CH = GPIO_OUT_CH_DEF,
    parameter int IO_CH  = GPIO_IO_CH_DEF,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    gpio_ctrl_if.slave        bus,
    input  logic [IN_CH-1:0]  GPIOIn,
    output logic [OUT_CH-1:0] GPIOOut,
    input  logic [IO_CH-1:0]  GPIOIOIn,
    output logic [IO_CH-1:0]  GPIOIOOut,
    output logic [IO_CH-1:0]  GPIOIOOe,
    output logic              Irq
);
    logic [ADDR_W-1:0] addr;
    gpio_addr_t        reg_sel;
    logic              req, wr, rd;
    logic [DATA_W-1:0] rd_val;
    logic [IN_CH-1:0]  in_sync, in_rise, in_fall;
    logic [IO_CH-1:0]  io_sync, io_rise, io_fall;
    logic [OUT_CH-1:0] out_data;
    logic [IO_CH-1:0]  io_out, io_dir;
    logic              unused_bits;

    assign addr    = bus.Addr;
    assign reg_sel = addr[GPIO_ADDR_MSB:GPIO_ADDR_LSB];
    assign req     = (bus.CS_ == ENABLE_) && (bus.As_ == ENABLE_);
    assign wr      = req && (bus.RW == WRITE);
    assign rd      = req && (bus.RW == READ);

    gpio_sync_edge #(.WIDTH(IN_CH)) u_in_sync (
        .clk(clk), .reset(reset), .pin(GPIOIn),
        .sync(in_sync), .rise(in_rise), .fall(in_fall)
    );

    gpio_sync_edge #(.WIDTH(IO_CH)) u_io_sync (
        .clk(clk), .reset(reset), .pin(GPIOIOIn),
        .sync(io_sync), .rise(io_rise), .fall(io_fall)
    );

`ifdef GPIO_IRQ_EN
    logic [IN_CH-1:0] irq_mask, irq_edge, irq_status, irq_evt, w1c;
    logic [1:0]       warm;

    // Hold off edge detection until the synchroniser has flushed its reset value
    assign irq_evt = (warm == 2'd3) ?
                     ((in_rise & ~irq_edge) | (in_fall & irq_edge)) : '0;
    assign w1c     = (wr && reg_sel == GPIO_ADDR_IRQ_STATUS) ? bus.WrData[IN_CH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask   <= '0;
            irq_edge   <= '0;
            irq_status <= '0;
            warm       <= '0;
            Irq        <= 1'b0;
        end else begin
            if (warm != 2'd3) warm <= warm + 2'd1;
            if (wr && reg_sel == GPIO_ADDR_IRQ_MASK) irq_mask <= bus.WrData[IN_CH-1:0];
            if (wr && reg_sel == GPIO_ADDR_IRQ_EDGE) irq_edge <= bus.WrData[IN_CH-1:0];
            irq_status <= (irq_status & ~w1c) | irq_evt;
            Irq        <= |(irq_status & irq_mask);
        end
    end

    assign unused_bits = ^{io_rise, io_fall, addr, bus.WrData};
`else
    assign Irq         = 1'b0;
    assign unused_bits = ^{in_rise, in_fall, io_rise, io_fall, addr, bus.WrData};
`endif

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            GPIO_ADDR_IN_DATA:    rd_val = DATA_W'(in_sync);
            GPIO_ADDR_OUT_DATA:   rd_val = DATA_W'(out_data);
            GPIO_ADDR_IO_DATA:    rd_val = DATA_W'(io_sync);
            GPIO_ADDR_IO_DIR:     rd_val = DATA_W'(io_dir);
`ifdef GPIO_IRQ_EN
            GPIO_ADDR_IRQ_MASK:   rd_val = DATA_W'(irq_mask);
            GPIO_ADDR_IRQ_EDGE:   rd_val = DATA_W'(irq_edge);
            GPIO_ADDR_IRQ_STATUS: rd_val = DATA_W'(irq_status);
`endif
            default:              rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Rdy_   <= DISABLE_;
            bus.RdData <= '0;
            out_data   <= '1;
            io_out     <= '0;
            io_dir     <= '0;
        end else begin
            bus.Rdy_   <= req ? ENABLE_ : DISABLE_;
            bus.RdData <= rd ? rd_val : '0;
            if (wr) begin
                case (reg_sel)
                    GPIO_ADDR_OUT_DATA: out_data <= bus.WrData[OUT_CH-1:0];
                    GPIO_ADDR_OUT_SET:  out_data <= out_data | bus.WrData[OUT_CH-1:0];
                    GPIO_ADDR_OUT_CLR:  out_data <= out_data & ~bus.WrData[OUT_CH-1:0];
                    GPIO_ADDR_IO_DATA:  io_out   <= bus.WrData[IO_CH-1:0];
                    GPIO_ADDR_IO_DIR:   io_dir   <= bus.WrData[IO_CH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign GPIOOut   = out_data;
    assign GPIOIOOut = io_out;
    assign GPIOIOOe  = io_dir;
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl; the interrupt section adapts to whether GPIO_IRQ_EN is defined.
module tb_gpio_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_in, gpio_out, gpio_io_in, gpio_io_out, gpio_io_oe;
    logic       irq;
    int         n_cmp = 0;
    int         n_err = 0;

    gpio_ctrl_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    gpio_ctrl #(.IN_CH(8), .OUT_CH(8), .IO_CH(8), .ADDR_W(30), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .GPIOIn(gpio_in), .GPIOOut(gpio_out),
        .GPIOIOIn(gpio_io_in), .GPIOIOOut(gpio_io_out), .GPIOIOOe(gpio_io_oe),
        .Irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.CS_ = 1'b1; bus.As_ = 1'b1; bus.RW = 1'b1;
        bus.Addr = '0;  bus.WrData = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.CS_ = 1'b0; bus.As_ = 1'b0; bus.RW = 1'b0;
        bus.Addr = {26'd0, a}; bus.WrData = d;
        tick();
        idle();
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus.CS_ = 1'b0; bus.As_ = 1'b0; bus.RW = 1'b1;
        bus.Addr = {26'd0, a};
        tick();
        chk({tag, " rdy"}, 32'(bus.Rdy_), 32'd0);
        chk(tag, bus.RdData, exp);
        idle();
        tick();
        chk({tag, " rdy_off"}, 32'(bus.Rdy_), 32'd1);
        chk({tag, " rd_idle"}, bus.RdData, 32'd0);
    endtask

    initial begin
        idle();
        reset = 1'b1; gpio_in = 8'h5A; gpio_io_in = 8'h3C;
        tick(); tick();
        // Reset state
        chk("rst rdy", 32'(bus.Rdy_), 32'd1);
        chk("rst rddata", bus.RdData, 32'd0);
        chk("rst gpio_out", 32'(gpio_out), 32'hFF);
        chk("rst io_out", 32'(gpio_io_out), 32'h0);
        chk("rst io_oe", 32'(gpio_io_oe), 32'h0);
        chk("rst irq", 32'(irq), 32'd0);
        reset = 1'b0;
        tick(); tick(); tick();

        // Register map after reset
        bus_read(4'd0, 32'h5A, "rd in_data");
        bus_read(4'd1, 32'hFF, "rd out_data");
        bus_read(4'd2, 32'h00, "rd out_set");
        bus_read(4'd3, 32'h00, "rd out_clr");
        bus_read(4'd4, 32'h3C, "rd io_data");
        bus_read(4'd5, 32'h00, "rd io_dir");
        bus_read(4'd6, 32'h00, "rd irq_mask");
        bus_read(4'd7, 32'h00, "rd irq_edge");
        bus_read(4'd8, 32'h00, "rd irq_status");
        bus_read(4'd9, 32'h00, "rd addr9");
        bus_read(4'd15, 32'h00, "rd addr15");

        // Output set/clear
        bus_write(4'd1, 32'hA5);
        chk("out write", 32'(gpio_out), 32'hA5);
        bus_write(4'd2, 32'h0A);
        chk("out set", 32'(gpio_out), 32'hAF);
        bus_write(4'd3, 32'h81);
        chk("out clr", 32'(gpio_out), 32'h2E);
        bus_read(4'd1, 32'h2E, "rd out after clr");
        bus_write(4'd0, 32'hFF);
        bus_read(4'd0, 32'h5A, "in_data ro");

        // Bidirectional pins and synchroniser latency
        bus_write(4'd5, 32'h0F);
        chk("io oe", 32'(gpio_io_oe), 32'h0F);
        bus_write(4'd4, 32'h33);
        chk("io out", 32'(gpio_io_out), 32'h33);
        gpio_io_in = 8'hC0;
        bus.CS_ = 1'b0; bus.As_ = 1'b0; bus.RW = 1'b1; bus.Addr = 30'd4;
        tick();
        chk("io sync c1", bus.RdData, 32'h3C);
        tick();
        chk("io sync c2", bus.RdData, 32'h3C);
        tick();
        chk("io sync c3", bus.RdData, 32'hC0);
        chk("io sync rdy", 32'(bus.Rdy_), 32'd0);
        idle();
        tick();

`ifdef GPIO_IRQ_EN
        // Rising-edge interrupt on bit 0
        bus_write(4'd6, 32'h01);
        bus_write(4'd7, 32'h00);
        bus_read(4'd6, 32'h01, "rd mask");
        gpio_in = 8'h5B;
        tick(); tick();
        chk("irq early", 32'(irq), 32'd0);
        tick();
        chk("irq c3", 32'(irq), 32'd0);
        tick();
        chk("irq c4", 32'(irq), 32'd1);
        bus_read(4'd8, 32'h01, "rd status edge");
        bus_write(4'd8, 32'h01);
        chk("irq after w1c c1", 32'(irq), 32'd1);
        tick();
        chk("irq after w1c c2", 32'(irq), 32'd0);
        bus_read(4'd8, 32'h00, "rd status cleared");

        // W1C coinciding with a fresh rising edge
        gpio_in = 8'h5A;
        tick(); tick(); tick(); tick();
        gpio_in = 8'h5B;
        tick(); tick(); tick(); tick(); tick();
        chk("irq set again", 32'(irq), 32'd1);
        gpio_in = 8'h5A;
        tick(); tick(); tick(); tick();
        bus_read(4'd8, 32'h01, "fall ignored");
        gpio_in = 8'h5B;
        tick(); tick();
        bus_write(4'd8, 32'h01);
        tick();
        chk("irq race", 32'(irq), 32'd1);
        bus_read(4'd8, 32'h01, "status race");

        // Falling-edge select
        bus_write(4'd8, 32'h01);
        bus_write(4'd7, 32'h01);
        bus_read(4'd7, 32'h01, "rd edge");
        bus_read(4'd8, 32'h00, "edge sel no event");
        gpio_in = 8'h5A;
        tick(); tick(); tick(); tick();
        bus_read(4'd8, 32'h01, "status fall");
`else
        bus_write(4'd6, 32'hFF);
        bus_read(4'd6, 32'h00, "mask absent");
        gpio_in = 8'h5B;
        tick(); tick(); tick(); tick(); tick();
        chk("irq tied", 32'(irq), 32'd0);
        bus_read(4'd8, 32'h00, "status absent");
`endif

        // Reset during a transaction, then reset with all pins high
        bus.CS_ = 1'b0; bus.As_ = 1'b0; bus.RW = 1'b1; bus.Addr = 30'd1;
        tick();
        chk("pre rst rd", bus.RdData, 32'h2E);
        reset = 1'b1; gpio_in = 8'hFF;
        tick();
        chk("mid rst rdy", 32'(bus.Rdy_), 32'd1);
        chk("mid rst rddata", bus.RdData, 32'd0);
        chk("mid rst out", 32'(gpio_out), 32'hFF);
        idle();
        tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        bus_read(4'd8, 32'h00, "no spurious status");
        bus_read(4'd0, 32'hFF, "in after rst");
        chk("no spurious irq", 32'(irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
